// File: rtl/div_pkg.sv
// Shared definitions for the divYR divider and its mul_add_seq round-trip partner.
// Both blocks take their default operand width from here so they always agree.
//   DIV_WIDTH : default operand/result width in bits
//   state_t   : three-state sequencing used by the iterative engines
package div_pkg;

  localparam int unsigned DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul_add_seq.sv
// Iterative radix-2 shift-add engine computing dividend = quotient * divisor + remainder.
// Inverse of divYR; used to check its results and to round-trip its vectors.
// Fixed latency of WIDTH iterations regardless of operand values.
//
// Ports:
//   clk          : clock, all state updates on the rising edge
//   reset_n      : asynchronous active-low reset, aborts any operation in flight
//   start        : request, sampled only in IDLE
//   quotient_in  : multiplier, captured on the accepted start
//   divisor_in   : multiplicand, captured on the accepted start
//   remainder_in : addend, captured on the accepted start
//   busy         : high in CALC and DONE
//   ready        : one-cycle pulse in DONE; results valid from this cycle
//   dividend_out : low WIDTH bits of q*d+r, held until the next DONE
//   overflow     : q*d+r >= 2^WIDTH
//   invalid      : remainder_in >= divisor_in (includes divisor_in == 0)
module mul_add_seq
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] quotient_in,
  input  logic [WIDTH-1:0] divisor_in,
  input  logic [WIDTH-1:0] remainder_in,
  output logic             busy,
  output logic             ready,
  output logic [WIDTH-1:0] dividend_out,
  output logic             overflow,
  output logic             invalid
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 inv_r_q, inv_r_d;
  logic [WIDTH-1:0]     dividend_q, dividend_d;
  logic                 ovf_q, ovf_d;
  logic                 inv_q, inv_d;

  // Accumulator value after the current iteration; the 2*WIDTH width cannot wrap.
  logic [2*WIDTH-1:0]   acc_sum;

  always_comb begin
    acc_sum = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    cnt_d      = cnt_q;
    inv_r_d    = inv_r_q;
    dividend_d = dividend_q;
    ovf_d      = ovf_q;
    inv_d      = inv_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = CALC;
          acc_d    = {{WIDTH{1'b0}}, remainder_in};
          mcand_d  = {{WIDTH{1'b0}}, divisor_in};
          mplier_d = quotient_in;
          cnt_d    = '0;
          inv_r_d  = (remainder_in >= divisor_in);
        end
      end
      CALC: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CntW'(1);
        // Outputs update only on the final iteration so they never glitch mid-calc.
        if (cnt_q == LastCnt) begin
          state_d    = DONE;
          dividend_d = acc_sum[WIDTH-1:0];
          ovf_d      = |acc_sum[2*WIDTH-1:WIDTH];
          inv_d      = inv_r_q;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      cnt_q      <= '0;
      inv_r_q    <= 1'b0;
      dividend_q <= '0;
      ovf_q      <= 1'b0;
      inv_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      cnt_q      <= cnt_d;
      inv_r_q    <= inv_r_d;
      dividend_q <= dividend_d;
      ovf_q      <= ovf_d;
      inv_q      <= inv_d;
    end
  end

  always_comb begin
    busy         = (state_q == CALC) || (state_q == DONE);
    ready        = (state_q == DONE);
    dividend_out = dividend_q;
    overflow     = ovf_q;
    invalid      = inv_q;
  end

endmodule

// File: tb/tb_mul_add_seq.sv
// Directed-vector bench for mul_add_seq with hand-computed expected results.
module tb_mul_add_seq;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [W-1:0] q, d, r;
  logic         busy, ready, overflow, invalid;
  logic [W-1:0] dividend_out;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mul_add_seq #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .quotient_in  (q),
    .divisor_in   (d),
    .remainder_in (r),
    .busy         (busy),
    .ready        (ready),
    .dividend_out (dividend_out),
    .overflow     (overflow),
    .invalid      (invalid)
  );

  // Waits for IDLE, then issues a one-cycle start; returns #1 after the accepting edge.
  task automatic start_op(input logic [W-1:0] qq, input logic [W-1:0] dd,
                          input logic [W-1:0] rr);
    int guard;
    guard = 0;
    while (busy && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    @(negedge clk);
    q = qq; d = dd; r = rr; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Bounded wait for ready; cycles counts edges after the accepting edge.
  task automatic wait_ready(output int cycles, output bit seen);
    seen = 1'b0;
    cycles = 0;
    while (!seen && cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
      if (ready) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; q = '0; d = '0; r = '0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", ready); end
    n_vec++; if (dividend_out !== 32'd0) begin
      n_err++; $display("FAIL reset_dividend: got %h want 0", dividend_out);
    end
    n_vec++; if ({overflow, invalid} !== 2'b00) begin
      n_err++; $display("FAIL reset_flags: got %b want 00", {overflow, invalid});
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    int cyc; bit seen;
    start_op(32'd3, 32'd3, 32'd1);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b want 1", busy); end
    wait_ready(cyc, seen);
    n_vec++; if (!seen || cyc != 32) begin
      n_err++; $display("FAIL basic_latency: seen=%0b cycles=%0d want 32", seen, cyc);
    end
    n_vec++; if (dividend_out !== 32'd10) begin
      n_err++; $display("FAIL basic_dividend: got %0d want 10", dividend_out);
    end
    n_vec++; if ({overflow, invalid} !== 2'b00) begin
      n_err++; $display("FAIL basic_flags: got %b want 00", {overflow, invalid});
    end
    @(posedge clk); #1;
    n_vec++; if ({ready, busy} !== 2'b00) begin
      n_err++; $display("FAIL basic_pulse_end: ready,busy=%b want 00", {ready, busy});
    end
  endtask

  task automatic test_products();
    int cyc; bit seen;
    start_op(32'd20, 32'd5, 32'd0);
    wait_ready(cyc, seen);
    n_vec++; if (!seen || dividend_out !== 32'd100 || invalid !== 1'b0) begin
      n_err++; $display("FAIL prod_100: seen=%0b got %0d inv=%b want 100 inv=0",
                        seen, dividend_out, invalid);
    end
    start_op(32'd7, 32'd4, 32'd2);
    repeat (10) @(posedge clk);
    #1;
    n_vec++; if (dividend_out !== 32'd100) begin
      n_err++; $display("FAIL prod_hold_in_calc: got %0d want 100", dividend_out);
    end
    wait_ready(cyc, seen);
    n_vec++; if (!seen || dividend_out !== 32'd30 || invalid !== 1'b0) begin
      n_err++; $display("FAIL prod_30: seen=%0b got %0d inv=%b want 30 inv=0",
                        seen, dividend_out, invalid);
    end
  endtask

  task automatic test_overflow();
    int cyc; bit seen;
    start_op(32'hFFFF_FFFF, 32'd2, 32'd1);
    wait_ready(cyc, seen);
    n_vec++; if (!seen || dividend_out !== 32'hFFFF_FFFF) begin
      n_err++; $display("FAIL ovf_dividend: seen=%0b got %h want ffffffff", seen, dividend_out);
    end
    n_vec++; if ({overflow, invalid} !== 2'b10) begin
      n_err++; $display("FAIL ovf_flags: ovf,inv=%b want 10", {overflow, invalid});
    end
  endtask

  task automatic test_invalid();
    int cyc; bit seen;
    start_op(32'd7, 32'd4, 32'd5);
    wait_ready(cyc, seen);
    n_vec++; if (!seen || dividend_out !== 32'd33 || invalid !== 1'b1) begin
      n_err++; $display("FAIL inv_rem_ge_div: seen=%0b got %0d inv=%b want 33 inv=1",
                        seen, dividend_out, invalid);
    end
    start_op(32'd5, 32'd0, 32'd9);
    wait_ready(cyc, seen);
    n_vec++; if (!seen || dividend_out !== 32'd9 || {overflow, invalid} !== 2'b01) begin
      n_err++; $display("FAIL inv_div_zero: seen=%0b got %0d ovf,inv=%b want 9 01",
                        seen, dividend_out, {overflow, invalid});
    end
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (dividend_out !== 32'd9 || invalid !== 1'b1) begin
      n_err++; $display("FAIL inv_hold: got %0d inv=%b want 9 inv=1", dividend_out, invalid);
    end
  endtask

  task automatic test_start_during_calc();
    int pulses;
    logic [W-1:0] res;
    start_op(32'd3, 32'd3, 32'd1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    q = 32'd99; d = 32'd7; r = 32'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pulses = 0;
    res = '0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (ready) begin pulses++; res = dividend_out; end
    end
    n_vec++; if (pulses != 1) begin
      n_err++; $display("FAIL ignore_pulses: got %0d want 1", pulses);
    end
    n_vec++; if (res !== 32'd10) begin
      n_err++; $display("FAIL ignore_result: got %0d want 10", res);
    end
  endtask

  task automatic test_back_to_back();
    int t[3];
    int np, cyc;
    @(negedge clk);
    q = 32'd20; d = 32'd5; r = 32'd0; start = 1'b1;
    np = 0; cyc = 0;
    while (np < 3 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (ready) begin t[np] = cyc; np++; end
    end
    start = 1'b0;
    n_vec++; if (np != 3) begin n_err++; $display("FAIL b2b_count: got %0d want 3", np); end
    n_vec++; if (np == 3 && t[1] - t[0] != 34) begin
      n_err++; $display("FAIL b2b_gap1: got %0d want 34", t[1] - t[0]);
    end
    n_vec++; if (np == 3 && t[2] - t[1] != 34) begin
      n_err++; $display("FAIL b2b_gap2: got %0d want 34", t[2] - t[1]);
    end
    n_vec++; if (dividend_out !== 32'd100) begin
      n_err++; $display("FAIL b2b_result: got %0d want 100", dividend_out);
    end
  endtask

  task automatic test_abort_reset();
    int cyc, pulses; bit seen;
    start_op(32'd3, 32'd3, 32'd1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_vec++; if ({busy, ready} !== 2'b00) begin
      n_err++; $display("FAIL abort_busy: busy,ready=%b want 00", {busy, ready});
    end
    n_vec++; if (dividend_out !== 32'd0 || {overflow, invalid} !== 2'b00) begin
      n_err++; $display("FAIL abort_outputs: got %0d flags=%b want 0 00",
                        dividend_out, {overflow, invalid});
    end
    @(negedge clk);
    reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ready) pulses++;
    end
    n_vec++; if (pulses != 0) begin
      n_err++; $display("FAIL abort_no_ready: got %0d pulses want 0", pulses);
    end
    start_op(32'd10, 32'd10, 32'd0);
    wait_ready(cyc, seen);
    n_vec++; if (!seen || cyc != 32) begin
      n_err++; $display("FAIL abort_next_latency: seen=%0b cycles=%0d want 32", seen, cyc);
    end
    n_vec++; if (dividend_out !== 32'd100 || {overflow, invalid} !== 2'b00) begin
      n_err++; $display("FAIL abort_next_result: got %0d flags=%b want 100 00",
                        dividend_out, {overflow, invalid});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_products();
    test_overflow();
    test_invalid();
    test_start_during_calc();
    test_back_to_back();
    test_abort_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
